pid_pwm_out: RTL and testbench

PID_PWM_OUT -- requirements
Module: pid_pwm_out

---
 rtl/pid_pkg.sv | 35 +++
 rtl/pid_deadtime.sv | 45 ++++
 rtl/pid_pwm_out.sv | 129 ++++++++++++
 tb/tb_pid_pwm_out.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID PWM output stage.
// Holds control-word default width, counter width and the duty clamp.
package pid_pkg;

   localparam int CW_DEF = 32;
   localparam int CNT_W  = 16;

   typedef logic signed [CW_DEF-1:0] ctrl_t;
   typedef logic [CNT_W-1:0]         cnt_t;

   typedef struct packed {
      logic sat;
      cnt_t val;
   } clamp_t;

   // Clamp a sign-extended control word to 0..per.
   // The compare runs on all 64 bits so large words never alias.
   function automatic clamp_t pid_clamp(
      input logic signed [63:0] x,
      input cnt_t               per
   );
      clamp_t r;
      r.sat = 1'b0;
      r.val = x[CNT_W-1:0];
      if (x < 64'sd0) begin
         r.sat = 1'b1;
         r.val = '0;
      end else if (x > $signed({48'd0, per})) begin
         r.sat = 1'b1;
         r.val = per;
      end
      return r;
   endfunction

endpackage

// File: rtl/pid_deadtime.sv
// Rising-edge delay for one gate drive; falling edges pass after 1 cycle.
// Ports: clk, rst_n, in_i (raw drive), out_o (registered, delayed rise).
module pid_deadtime
   import pid_pkg::*;
#(
   parameter int DT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_i,
   output logic out_o
);

   localparam cnt_t DT_C = cnt_t'(DT);

   cnt_t cnt_q, cnt_d;
   logic out_q, out_d;

   // Output rises only once the input has stayed high for DT cycles,
   // so a pulse of DT cycles or less never reaches the pin.
   always_comb begin
      cnt_d = cnt_q;
      out_d = 1'b0;
      if (!in_i) begin
         cnt_d = '0;
      end else if (cnt_q == DT_C) begin
         out_d = 1'b1;
      end else begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/pid_pwm_out.sv
// PWM output stage: clamps PI control words into a shadow duty register
// and applies them at the period wrap. Ports: clk, rst_n, ctrl_valid,
// ctrl_data, ctrl_ready, pwm_hi, pwm_lo, sat_flag, period_start.
// Macro PID_PWM_DEADTIME_EN enables complementary low side + dead time.
module pid_pwm_out
   import pid_pkg::*;
#(
   parameter int CW     = CW_DEF,
   parameter int PERIOD = 1000,
   parameter int DT     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ctrl_valid,
   input  logic signed [CW-1:0] ctrl_data,
   output logic                 ctrl_ready,
   output logic                 pwm_hi,
   output logic                 pwm_lo,
   output logic                 sat_flag,
   output logic                 period_start
);

   if (PERIOD < 2 || PERIOD > 65535) begin : g_bad_period
      $error("pid_pwm_out: PERIOD out of range");
   end
   if (DT < 1 || DT > PERIOD / 4) begin : g_bad_dt
      $error("pid_pwm_out: DT out of range");
   end

   localparam cnt_t PER  = cnt_t'(PERIOD);
   localparam cnt_t LAST = cnt_t'(PERIOD - 1);

   cnt_t cnt_q, cnt_d;
   cnt_t duty_q, duty_d;
   cnt_t shadow_q, shadow_d;
   logic shadow_sat_q, shadow_sat_d;
   logic shadow_full_q, shadow_full_d;
   logic sat_q, sat_d;

   logic               wrap;
   logic               accept;
   logic               raw;
   logic signed [63:0] ctrl_ext;
   clamp_t             cl;

   assign wrap     = (cnt_q == LAST);
   assign ctrl_ext = 64'(ctrl_data);
   assign cl       = pid_clamp(ctrl_ext, PER);

   // Gated with rst_n so the slot reads busy while held in reset.
   assign ctrl_ready = rst_n & ~shadow_full_q;
   assign accept     = ctrl_valid & ctrl_ready;

   always_comb begin
      cnt_d         = wrap ? '0 : cnt_q + cnt_t'(1);
      duty_d        = duty_q;
      sat_d         = sat_q;
      shadow_d      = shadow_q;
      shadow_sat_d  = shadow_sat_q;
      shadow_full_d = shadow_full_q;
      // A full slot blocks acceptance, so load and accept never collide;
      // a word taken in the wrap cycle waits for the next wrap.
      if (wrap && shadow_full_q) begin
         duty_d        = shadow_q;
         sat_d         = shadow_sat_q;
         shadow_full_d = 1'b0;
      end else if (accept) begin
         shadow_d      = cl.val;
         shadow_sat_d  = cl.sat;
         shadow_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         duty_q        <= '0;
         sat_q         <= 1'b0;
         shadow_q      <= '0;
         shadow_sat_q  <= 1'b0;
         shadow_full_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         duty_q        <= duty_d;
         sat_q         <= sat_d;
         shadow_q      <= shadow_d;
         shadow_sat_q  <= shadow_sat_d;
         shadow_full_q <= shadow_full_d;
      end
   end

   assign raw          = (cnt_q < duty_q);
   assign sat_flag     = sat_q;
   assign period_start = (cnt_q == '0);

`ifdef PID_PWM_DEADTIME_EN
   pid_deadtime #(
      .DT(DT)
   ) u_dt_hi (
      .clk  (clk),
      .rst_n(rst_n),
      .in_i (raw),
      .out_o(pwm_hi)
   );

   pid_deadtime #(
      .DT(DT)
   ) u_dt_lo (
      .clk  (clk),
      .rst_n(rst_n),
      .in_i (~raw),
      .out_o(pwm_lo)
   );
`else
   logic pwm_hi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_hi_q <= 1'b0;
      end else begin
         pwm_hi_q <= raw;
      end
   end

   assign pwm_hi = pwm_hi_q;
   assign pwm_lo = 1'b0;
`endif

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out with PERIOD=10, DT=2.
// Expected pwm patterns are hand-derived per period (bit i = cnt i).
module tb_pid_pwm_out;

   logic        clk;
   logic        rst_n;
   logic        ctrl_valid;
   logic [31:0] ctrl_data;
   logic        ctrl_ready;
   logic        pwm_hi;
   logic        pwm_lo;
   logic        sat_flag;
   logic        period_start;

   int ntests = 0;
   int nfail  = 0;

   pid_pwm_out #(
      .CW    (32),
      .PERIOD(10),
      .DT    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctrl_valid  (ctrl_valid),
      .ctrl_data   (ctrl_data),
      .ctrl_ready  (ctrl_ready),
      .pwm_hi      (pwm_hi),
      .pwm_lo      (pwm_lo),
      .sat_flag    (sat_flag),
      .period_start(period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sync_to(input int k);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (period_start) found = 1'b1;
      end
      chk("sync", {31'd0, found}, 32'd1);
      repeat (k) step();
   endtask

   task automatic cap(output logic [9:0] hi, output logic [9:0] lo);
      for (int i = 0; i < 10; i++) begin
         hi[i] = pwm_hi;
         lo[i] = pwm_lo;
         step();
      end
   endtask

   task automatic send(input logic [31:0] v);
      ctrl_valid = 1'b1;
      ctrl_data  = v;
      chk("send_ready", {31'd0, ctrl_ready}, 32'd1);
      step();
      ctrl_valid = 1'b0;
   endtask

   logic [9:0] hi, lo;
   int         n;

   initial begin
      rst_n      = 1'b0;
      ctrl_valid = 1'b0;
      ctrl_data  = '0;
      repeat (3) step();
      chk("rst_hi", {31'd0, pwm_hi}, 32'd0);
      chk("rst_lo", {31'd0, pwm_lo}, 32'd0);
      chk("rst_sat", {31'd0, sat_flag}, 32'd0);
      chk("rst_ready", {31'd0, ctrl_ready}, 32'd0);
      chk("rst_pstart", {31'd0, period_start}, 32'd1);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", {31'd0, ctrl_ready}, 32'd1);

`ifndef PID_PWM_DEADTIME_EN
      // duty 4 accepted at cnt 3
      sync_to(3);
      send(32'd4);
      sync_to(0);
      cap(hi, lo);
      chk("duty4_hi", {22'd0, hi}, 32'h01E);
      chk("duty4_lo", {22'd0, lo}, 32'h000);
      chk("duty4_sat", {31'd0, sat_flag}, 32'd0);

      // negative word clamps to 0
      send(32'hFFFF_FFFB);
      sync_to(0);
      cap(hi, lo);
      chk("neg_hi", {22'd0, hi}, 32'h000);
      chk("neg_sat", {31'd0, sat_flag}, 32'd1);

      // huge word clamps to PERIOD
      send(32'h7FFF_FFFF);
      sync_to(0);
      cap(hi, lo);
      chk("max_first", {22'd0, hi}, 32'h3FE);
      cap(hi, lo);
      chk("max_steady", {22'd0, hi}, 32'h3FF);
      chk("max_sat", {31'd0, sat_flag}, 32'd1);

      // back-to-back 3 then 7, second stalls until wrap
      ctrl_valid = 1'b1;
      ctrl_data  = 32'd3;
      step();
      ctrl_data = 32'd7;
      chk("b2b_stall", {31'd0, ctrl_ready}, 32'd0);
      n = 0;
      while (!ctrl_ready && n < 20) begin
         step();
         n++;
      end
      chk("stall_ends", {31'd0, ctrl_ready}, 32'd1);
      chk("stall_at_wrap", {31'd0, period_start}, 32'd1);
      hi[0] = pwm_hi;
      step();
      ctrl_valid = 1'b0;
      for (int i = 1; i < 10; i++) begin
         hi[i] = pwm_hi;
         step();
      end
      chk("b2b_duty3", {22'd0, hi}, 32'h00F);
      chk("b2b_sat", {31'd0, sat_flag}, 32'd0);
      cap(hi, lo);
      chk("b2b_duty7", {22'd0, hi}, 32'h0FE);

      // accepted in the wrap cycle: skips the immediate wrap
      sync_to(9);
      send(32'd2);
      chk("wrap_held", {31'd0, ctrl_ready}, 32'd0);
      cap(hi, lo);
      chk("wrap_old", {22'd0, hi}, 32'h0FE);
      cap(hi, lo);
      chk("wrap_new", {22'd0, hi}, 32'h006);
      chk("wrap_ready", {31'd0, ctrl_ready}, 32'd1);

      // reset mid-period with a pending shadow
      send(32'd5);
      sync_to(1);
      send(32'd6);
      chk("pre_rst_hi", {31'd0, pwm_hi}, 32'd1);
      chk("pre_rst_rdy", {31'd0, ctrl_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_hi", {31'd0, pwm_hi}, 32'd0);
      chk("arst_lo", {31'd0, pwm_lo}, 32'd0);
      chk("arst_rdy", {31'd0, ctrl_ready}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rdy", {31'd0, ctrl_ready}, 32'd1);
      chk("post_pstart", {31'd0, period_start}, 32'd1);
      cap(hi, lo);
      chk("post_duty0", {22'd0, hi}, 32'h000);
      cap(hi, lo);
      chk("post_discard", {22'd0, hi}, 32'h000);
      chk("post_sat", {31'd0, sat_flag}, 32'd0);
`else
      // duty 5 with 2-cycle dead time
      send(32'd5);
      sync_to(0);
      cap(hi, lo);
      cap(hi, lo);
      chk("dt5_hi", {22'd0, hi}, 32'h038);
      chk("dt5_lo", {22'd0, lo}, 32'h301);
      chk("dt5_overlap", {22'd0, hi & lo}, 32'h000);

      // duty 1 is shorter than DT: high side suppressed
      send(32'd1);
      sync_to(0);
      cap(hi, lo);
      cap(hi, lo);
      chk("dt1_hi", {22'd0, hi}, 32'h000);
      chk("dt1_lo", {22'd0, lo}, 32'h3F1);
      chk("dt1_sat", {31'd0, sat_flag}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
